// File: rtl/hd44780_fifo.sv
// hd44780_fifo: single-clock FIFO with registered status, count and sticky error flags.
// Define HD44780_FIFO_FWFT_EN to select first-word-fall-through read mode (default: standard mode).
module hd44780_fifo #(
    parameter int data_width  = 16,
    parameter int addr_width  = 8,
    parameter int afull_level = (1 << addr_width) - 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [data_width-1:0] din,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [data_width-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic [addr_width:0]   count,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int unsigned DEPTH = 1 << addr_width;
    localparam logic [addr_width:0]   DEPTH_C = (addr_width+1)'(DEPTH);
    localparam logic [addr_width:0]   AFULL_C = (addr_width+1)'(afull_level);
    localparam logic [addr_width:0]   CNT_ONE = (addr_width+1)'(1);
    localparam logic [addr_width-1:0] PTR_ONE = addr_width'(1);

    logic [data_width-1:0] mem [0:DEPTH-1];

    logic [addr_width-1:0] wr_ptr_q, wr_ptr_d;
    logic [addr_width-1:0] rd_ptr_q, rd_ptr_d;
    logic [addr_width:0]   count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  afull_q, afull_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic [data_width-1:0] dout_q;

    logic wr_acc;
    logic rd_acc;
    logic ram_rd;

`ifdef HD44780_FIFO_FWFT_EN
    typedef enum logic [1:0] {IDLE, LOAD, VALID} state_t;
    state_t              state_q, state_d;
    logic [addr_width:0] ram_cnt_q, ram_cnt_d;
`endif

    // A write into a full FIFO is only taken when a read frees a slot in the same cycle.
    always_comb begin
        rd_acc = rd_en && !empty_q;
        wr_acc = wr_en && (!full_q || rd_acc);

        count_d = count_q;
        if (wr_acc && !rd_acc) begin
            count_d = count_q + CNT_ONE;
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CNT_ONE;
        end

        full_d  = (count_d == DEPTH_C);
        afull_d = (count_d >= AFULL_C);
        ovf_d   = ovf_q | (wr_en & ~wr_acc);
        udf_d   = udf_q | (rd_en & ~rd_acc);
    end

`ifdef HD44780_FIFO_FWFT_EN
    // dout is the prefetch register; LOAD spends one cycle on address setup before the fill.
    always_comb begin
        state_d = state_q;
        ram_rd  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ram_cnt_q != '0) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                ram_rd  = 1'b1;
                state_d = VALID;
            end
            VALID: begin
                if (rd_acc) begin
                    if (ram_cnt_q != '0) begin
                        ram_rd = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        ram_cnt_d = ram_cnt_q;
        if (wr_acc && !ram_rd) begin
            ram_cnt_d = ram_cnt_q + CNT_ONE;
        end else if (ram_rd && !wr_acc) begin
            ram_cnt_d = ram_cnt_q - CNT_ONE;
        end

        empty_d = (state_d != VALID);
    end
`else
    always_comb begin
        ram_rd  = rd_acc;
        empty_d = (count_d == '0);
    end
`endif

    always_comb begin
        wr_ptr_d = wr_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = ram_rd ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            afull_q   <= 1'b0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            dout_q    <= '0;
`ifdef HD44780_FIFO_FWFT_EN
            state_q   <= IDLE;
            ram_cnt_q <= '0;
`endif
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            afull_q   <= afull_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
            if (ram_rd) begin
                dout_q <= mem[rd_ptr_q];
            end
`ifdef HD44780_FIFO_FWFT_EN
            state_q   <= state_d;
            ram_cnt_q <= ram_cnt_d;
`endif
        end
    end

    // Storage array carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= din;
        end
    end

    assign dout        = dout_q;
    assign full        = full_q;
    assign empty       = empty_q;
    assign almost_full = afull_q;
    assign count       = count_q;
    assign overflow    = ovf_q;
    assign underflow   = udf_q;

endmodule
